// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: FSM state encodings, opcodes
// and the opcode-to-unit-enable decode.
package alu_seq_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GOT_A = 3'd1,
    EXEC  = 3'd2,
    DONE  = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } opcode_t;

  // Bit order of the returned vector: {add, xor, or, and}
  function automatic logic [3:0] op_onehot(input opcode_t op);
    logic [3:0] oh;
    oh = 4'b0000;
    case (op)
      OP_AND:  oh = 4'b0001;
      OP_OR:   oh = 4'b0010;
      OP_XOR:  oh = 4'b0100;
      OP_ADD:  oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce (BTN_DEBOUNCE_EN)
// and a registered rising-edge detector producing a one-cycle step pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step
);

  logic sync_p0;
  logic sync_p1;
  logic level;
  logic prev_p2;

  // Stage 0/1: metastability synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int DB_N  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CNT_W = $clog2(DB_N + 1);

  logic [CNT_W-1:0] db_cnt;
  logic             db_level;

  // The level only moves after the synchronized input has disagreed with it
  // for DB_N consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync_p1 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DB_N - 1)) begin
      db_cnt   <= '0;
      db_level <= sync_p1;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync_p1;
`endif

  // Stage 2: registered rising-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_p2 <= 1'b0;
      step    <= 1'b0;
    end else begin
      prev_p2 <= level;
      step    <= level & ~prev_p2;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Steps operand A, operand B/opcode capture and a single-cycle unit execution from
// button presses. Build option: BTN_DEBOUNCE_EN enables button debouncing.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W               = W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_next,
  input  logic [W-1:0]   sw_data,
  input  logic [1:0]     sw_op,
  input  logic [2*W-1:0] unit_res,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic           en_and,
  output logic           en_or,
  output logic           en_xor,
  output logic           en_add,
  output logic [2*W-1:0] result,
  output logic           result_valid,
  output logic [2:0]     state_dbg
);

  state_t     state;
  state_t     state_nxt;
  opcode_t    opcode;
  logic       step;
  logic [3:0] en_vec;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_next),
    .step (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // EXEC is unconditional and ignores step, so a press landing there is dropped.
  always_comb begin
    state_nxt = state;
    en_vec    = 4'b0000;
    case (state)
      IDLE:    if (step) state_nxt = GOT_A;
      GOT_A:   if (step) state_nxt = EXEC;
      EXEC: begin
        en_vec    = op_onehot(opcode);
        state_nxt = DONE;
      end
      DONE:    if (step) state_nxt = GOT_A;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a         <= '0;
      op_b         <= '0;
      opcode       <= OP_AND;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (step) op_a <= sw_data;
        GOT_A: if (step) begin
          op_b   <= sw_data;
          opcode <= opcode_t'(sw_op);
        end
        EXEC: begin
          result       <= unit_res;
          result_valid <= 1'b1;
        end
        DONE: if (step) begin
          op_a         <= sw_data;
          result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign en_and    = en_vec[0];
  assign en_or     = en_vec[1];
  assign en_xor    = en_vec[2];
  assign en_add    = en_vec[3];
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with behavioural AND/OR/XOR/ADD units.
module tb_alu_op_sequencer;

  localparam int W  = 4;
  localparam int DB = 4;
`ifdef BTN_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           btn_next;
  logic [W-1:0]   sw_data;
  logic [1:0]     sw_op;
  logic [2*W-1:0] unit_res;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           en_and, en_or, en_xor, en_add;
  logic [2*W-1:0] result;
  logic           result_valid;
  logic [2:0]     state_dbg;

  int total = 0;
  int bad   = 0;
  int n_and = 0, n_or = 0, n_xor = 0, n_add = 0;
  int a0, o0, x0, d0;

  alu_op_sequencer #(.W(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_next     (btn_next),
    .sw_data      (sw_data),
    .sw_op        (sw_op),
    .unit_res     (unit_res),
    .op_a         (op_a),
    .op_b         (op_b),
    .en_and       (en_and),
    .en_or        (en_or),
    .en_xor       (en_xor),
    .en_add       (en_add),
    .result       (result),
    .result_valid (result_valid),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  // Enable-gated units: output 0 unless enabled
  always_comb begin
    unit_res = '0;
    if (en_and) unit_res = {4'h0, op_a & op_b};
    if (en_or)  unit_res = {4'h0, op_a | op_b};
    if (en_xor) unit_res = {4'h0, op_a ^ op_b};
    if (en_add) unit_res = {4'h0, op_a} + {4'h0, op_b};
  end

  always @(posedge clk) begin
    if (en_and) n_and <= n_and + 1;
    if (en_or)  n_or  <= n_or + 1;
    if (en_xor) n_xor <= n_xor + 1;
    if (en_add) n_add <= n_add + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [W-1:0] d, input logic [1:0] op);
    sw_data  = d;
    sw_op    = op;
    btn_next = 1'b1;
    cyc(LAT + 3);
    btn_next = 1'b0;
    cyc(LAT + 3);
  endtask

  task automatic snap();
    a0 = n_and; o0 = n_or; x0 = n_xor; d0 = n_add;
  endtask

  initial begin
    rst = 1'b1; btn_next = 1'b0; sw_data = '0; sw_op = 2'b00;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    check("rst_outs", {op_a, op_b, result, result_valid, en_and, en_or, en_xor, en_add},
          32'd0);

    // Test 1: async reset while in GOT_A
    press(4'h5, 2'b00);
    check("t1_gota", {29'd0, state_dbg}, 32'd1);
    check("t1_opa", {28'd0, op_a}, 32'h5);
    #2 rst = 1'b1;
    #1;
    check("t1_async_state", {29'd0, state_dbg}, 32'd0);
    check("t1_async_outs", {op_a, op_b, result, result_valid, en_and, en_or, en_xor, en_add},
          32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Test 2: AND 0xC & 0xA, with latency probe on the first press
    sw_data = 4'hC; sw_op = 2'b00; btn_next = 1'b1;
    cyc(LAT);
    check("t2_lat_before", {29'd0, state_dbg}, 32'd0);
    cyc(1);
    check("t2_lat_after", {29'd0, state_dbg}, 32'd1);
    check("t2_opa", {28'd0, op_a}, 32'hC);
    cyc(2);
    btn_next = 1'b0;
    cyc(LAT + 3);
    snap();
    press(4'hA, 2'b00);
    check("t2_en_and_cnt", n_and - a0, 32'd1);
    check("t2_other_en", (n_or - o0) + (n_xor - x0) + (n_add - d0), 32'd0);
    check("t2_result", {24'd0, result}, 32'h08);
    check("t2_valid", {31'd0, result_valid}, 32'd1);
    check("t2_state", {29'd0, state_dbg}, 32'd3);
    check("t2_opb", {28'd0, op_b}, 32'hA);

    // Test 5: chained capture from DONE
    press(4'h3, 2'b01);
    check("t5_opa", {28'd0, op_a}, 32'h3);
    check("t5_valid", {31'd0, result_valid}, 32'd0);
    check("t5_result_held", {24'd0, result}, 32'h08);
    check("t5_state", {29'd0, state_dbg}, 32'd1);

    // OR 0x3 | 0x9 = 0xB
    snap();
    press(4'h9, 2'b01);
    check("or_result", {24'd0, result}, 32'h0B);
    check("or_en_cnt", n_or - o0, 32'd1);

    // XOR 0xC ^ 0xA = 0x6
    press(4'hC, 2'b00);
    snap();
    press(4'hA, 2'b10);
    check("xor_result", {24'd0, result}, 32'h06);
    check("xor_en_cnt", n_xor - x0, 32'd1);

    // Test 3: ADD 0xF + 0x1 = 0x10
    press(4'hF, 2'b10);
    snap();
    press(4'h1, 2'b11);
    check("t3_result", {24'd0, result}, 32'h10);
    check("t3_en_add_cnt", n_add - d0, 32'd1);
    check("t3_other_en", (n_and - a0) + (n_or - o0) + (n_xor - x0), 32'd0);
    check("t3_valid", {31'd0, result_valid}, 32'd1);

    // Test 4: button held 50 cycles from IDLE gives a single step
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    sw_data = 4'h7; btn_next = 1'b1;
    cyc(50);
    btn_next = 1'b0;
    cyc(LAT + 3);
    check("t4_state", {29'd0, state_dbg}, 32'd1);
    check("t4_opa", {28'd0, op_a}, 32'h7);

`ifdef BTN_DEBOUNCE_EN
    // Test 6: short glitch filtered, stable press accepted after 3+DB cycles
    sw_data = 4'h2; sw_op = 2'b00;
    btn_next = 1'b1;
    cyc(2);
    btn_next = 1'b0;
    cyc(12);
    check("t6_glitch", {29'd0, state_dbg}, 32'd1);
    btn_next = 1'b1;
    cyc(3 + DB);
    check("t6_before", {29'd0, state_dbg}, 32'd1);
    cyc(1);
    check("t6_after", {29'd0, state_dbg}, 32'd2);
    btn_next = 1'b0;
    cyc(12);
    check("t6_done", {29'd0, state_dbg}, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
